// File: rtl/matrix_print_tx.sv
// Prints an MxN matrix of 32-bit words from synchronous storage as decimal ASCII rows over an 8N1 UART.
// Define MATRIX_PRINT_HEADER_EN to emit a "<m> <n>" CR LF header line before the rows.
module matrix_print_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  base_addr,
    input  logic [2:0]  dim_m,
    input  logic [2:0]  dim_n,
    output logic        rd_en,
    output logic [7:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        uart_tx,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
`ifdef MATRIX_PRINT_HEADER_EN
        S_HEADER      = 4'd1,
`endif
        S_FETCH       = 4'd2,
        S_WAIT_DATA   = 4'd3,
        S_CONVERT     = 4'd4,
        S_SEND_DIGITS = 4'd5,
        S_SEND_SEP    = 4'd6,
        S_SEND_EOL    = 4'd7,
        S_DONE        = 4'd8
    } state_t;

    function automatic logic dim_ok(input logic [2:0] d);
        return (d != 3'd0) && (d <= 3'd5);
    endfunction

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
    function automatic logic [19:0] dabble_step(input logic [19:0] bcd, input logic bit_in);
        logic [19:0] adj;
        adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            else                       adj[i*4 +: 4] = adj[i*4 +: 4];
        end
        return {adj[18:0], bit_in};
    endfunction

    function automatic logic [2:0] lead_idx(input logic [19:0] bcd);
        if      (bcd[19:16] != 4'd0) return 3'd4;
        else if (bcd[15:12] != 4'd0) return 3'd3;
        else if (bcd[11:8]  != 4'd0) return 3'd2;
        else if (bcd[7:4]   != 4'd0) return 3'd1;
        else                         return 3'd0;
    endfunction

    function automatic logic [3:0] bcd_digit(input logic [19:0] bcd, input logic [2:0] idx);
        case (idx)
            3'd0:    return bcd[3:0];
            3'd1:    return bcd[7:4];
            3'd2:    return bcd[11:8];
            3'd3:    return bcd[15:12];
            3'd4:    return bcd[19:16];
            default: return 4'd0;
        endcase
    endfunction

`ifdef MATRIX_PRINT_HEADER_EN
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [2:0] m, input logic [2:0] n);
        case (idx)
            3'd0:    return 8'h30 + {5'd0, m};
            3'd1:    return 8'd32;
            3'd2:    return 8'h30 + {5'd0, n};
            3'd3:    return 8'd13;
            default: return 8'd10;
        endcase
    endfunction

    logic [2:0]  hdr_idx_q;
`endif

    state_t      state_q;
    logic [2:0]  m_q, n_q, row_q, col_q, dig_idx_q;
    logic [7:0]  elem_addr_q, rd_addr_q, tx_byte_q;
    logic [15:0] bin_q;
    logic [19:0] bcd_q;
    logic [3:0]  conv_cnt_q;
    logic        star_q, eol_lf_q, rd_en_q, busy_q, done_q, error_q, tx_start_q, tx_wait_q;
    logic        tx_active_q, tx_line_q, tx_done_q;
    logic [8:0]  tx_shift_q;
    logic [3:0]  tx_bit_q;
    logic [15:0] baud_q;
    logic [19:0] dabble_d;
    logic [7:0]  send_byte_s;
    logic        last_col_s, last_row_s;

    assign dabble_d   = dabble_step(bcd_q, bin_q[15]);
    assign last_col_s = (col_q == n_q - 3'd1);
    assign last_row_s = (row_q == m_q - 3'd1);

    // Byte the current sending state wants on the line.
    always_comb begin
        send_byte_s = 8'd32;
        case (state_q)
`ifdef MATRIX_PRINT_HEADER_EN
            S_HEADER:      send_byte_s = hdr_byte(hdr_idx_q, m_q, n_q);
`endif
            S_SEND_DIGITS: send_byte_s = star_q ? 8'd42 : {4'h3, bcd_digit(bcd_q, dig_idx_q)};
            S_SEND_SEP:    send_byte_s = 8'd32;
            S_SEND_EOL:    send_byte_s = eol_lf_q ? 8'd10 : 8'd13;
            default:       send_byte_s = 8'd32;
        endcase
    end

    // UART serialiser: frame = start bit, 8 data bits LSB first, stop bit; tx_done pulses as the stop bit ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_active_q <= 1'b0;
            tx_line_q   <= 1'b1;
            tx_done_q   <= 1'b0;
            tx_shift_q  <= 9'd0;
            tx_bit_q    <= 4'd0;
            baud_q      <= 16'd0;
        end else begin
            tx_done_q <= 1'b0;
            if (!tx_active_q) begin
                if (tx_start_q) begin
                    tx_active_q <= 1'b1;
                    tx_line_q   <= 1'b0;
                    tx_shift_q  <= {1'b1, tx_byte_q};
                    tx_bit_q    <= 4'd0;
                    baud_q      <= 16'd0;
                end else begin
                    tx_line_q <= 1'b1;
                end
            end else if (baud_q == BAUD_MAX) begin
                baud_q <= 16'd0;
                if (tx_bit_q == 4'd9) begin
                    tx_active_q <= 1'b0;
                    tx_done_q   <= 1'b1;
                    tx_line_q   <= 1'b1;
                end else begin
                    tx_line_q  <= tx_shift_q[0];
                    tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                    tx_bit_q   <= tx_bit_q + 4'd1;
                end
            end else begin
                baud_q <= baud_q + 16'd1;
            end
        end
    end

    // Print sequencer; every sending state issues one byte then waits for the serialiser to finish it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            m_q         <= 3'd0;
            n_q         <= 3'd0;
            row_q       <= 3'd0;
            col_q       <= 3'd0;
            dig_idx_q   <= 3'd0;
            elem_addr_q <= 8'd0;
            rd_addr_q   <= 8'd0;
            tx_byte_q   <= 8'd0;
            bin_q       <= 16'd0;
            bcd_q       <= 20'd0;
            conv_cnt_q  <= 4'd0;
            star_q      <= 1'b0;
            eol_lf_q    <= 1'b0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_wait_q   <= 1'b0;
`ifdef MATRIX_PRINT_HEADER_EN
            hdr_idx_q   <= 3'd0;
`endif
        end else begin
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            tx_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (dim_ok(dim_m) && dim_ok(dim_n)) begin
                            m_q         <= dim_m;
                            n_q         <= dim_n;
                            row_q       <= 3'd0;
                            col_q       <= 3'd0;
                            busy_q      <= 1'b1;
                            tx_wait_q   <= 1'b0;
                            elem_addr_q <= base_addr;
`ifdef MATRIX_PRINT_HEADER_EN
                            hdr_idx_q   <= 3'd0;
                            state_q     <= S_HEADER;
`else
                            rd_en_q     <= 1'b1;
                            rd_addr_q   <= base_addr;
                            state_q     <= S_FETCH;
`endif
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
`ifdef MATRIX_PRINT_HEADER_EN
                S_HEADER: begin
                    if (!tx_wait_q) begin
                        tx_start_q <= 1'b1;
                        tx_byte_q  <= send_byte_s;
                        tx_wait_q  <= 1'b1;
                    end else if (tx_done_q) begin
                        tx_wait_q <= 1'b0;
                        if (hdr_idx_q == 3'd4) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= elem_addr_q;
                            state_q   <= S_FETCH;
                        end else begin
                            hdr_idx_q <= hdr_idx_q + 3'd1;
                        end
                    end
                end
`endif
                S_FETCH: begin
                    elem_addr_q <= elem_addr_q + 8'd1;
                    state_q     <= S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    bin_q      <= rd_data[15:0];
                    star_q     <= |rd_data[31:16];
                    bcd_q      <= 20'd0;
                    conv_cnt_q <= 4'd0;
                    state_q    <= S_CONVERT;
                end
                S_CONVERT: begin
                    if (star_q) begin
                        dig_idx_q <= 3'd0;
                        state_q   <= S_SEND_DIGITS;
                    end else begin
                        bcd_q      <= dabble_d;
                        bin_q      <= {bin_q[14:0], 1'b0};
                        conv_cnt_q <= conv_cnt_q + 4'd1;
                        if (conv_cnt_q == 4'd15) begin
                            dig_idx_q <= lead_idx(dabble_d);
                            state_q   <= S_SEND_DIGITS;
                        end
                    end
                end
                S_SEND_DIGITS: begin
                    if (!tx_wait_q) begin
                        tx_start_q <= 1'b1;
                        tx_byte_q  <= send_byte_s;
                        tx_wait_q  <= 1'b1;
                    end else if (tx_done_q) begin
                        tx_wait_q <= 1'b0;
                        if (star_q || dig_idx_q == 3'd0) begin
                            eol_lf_q <= 1'b0;
                            state_q  <= last_col_s ? S_SEND_EOL : S_SEND_SEP;
                        end else begin
                            dig_idx_q <= dig_idx_q - 3'd1;
                        end
                    end
                end
                S_SEND_SEP: begin
                    if (!tx_wait_q) begin
                        tx_start_q <= 1'b1;
                        tx_byte_q  <= send_byte_s;
                        tx_wait_q  <= 1'b1;
                    end else if (tx_done_q) begin
                        tx_wait_q <= 1'b0;
                        col_q     <= col_q + 3'd1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= elem_addr_q;
                        state_q   <= S_FETCH;
                    end
                end
                S_SEND_EOL: begin
                    if (!tx_wait_q) begin
                        tx_start_q <= 1'b1;
                        tx_byte_q  <= send_byte_s;
                        tx_wait_q  <= 1'b1;
                    end else if (tx_done_q) begin
                        tx_wait_q <= 1'b0;
                        if (!eol_lf_q) begin
                            eol_lf_q <= 1'b1;
                        end else if (last_row_s) begin
                            col_q   <= 3'd0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            col_q     <= 3'd0;
                            row_q     <= row_q + 3'd1;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= elem_addr_q;
                            state_q   <= S_FETCH;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign uart_tx = tx_line_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;
endmodule

// File: tb/tb_matrix_print_tx.sv
// Scoreboard bench for matrix_print_tx: a string-level model predicts bytes and read addresses,
// independent monitors decode the UART line, the read strobe and done pulses and compare.
module tb_matrix_print_tx;
    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 192_000;
    localparam int CPB       = CLK_FREQ / BAUD_RATE;
    localparam int BUDGET    = 12000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = 8'd0;
    logic [2:0]  dim_m = 3'd0;
    logic [2:0]  dim_n = 3'd0;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        uart_tx, busy, done, error;

    logic [31:0] mem [0:255];
    logic [7:0]  exp_bytes [$];
    logic [7:0]  exp_addr [$];
    string       rx_str = "";
    string       crlf;
    int          rx_count = 0;
    int          done_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    matrix_print_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .dim_m(dim_m), .dim_n(dim_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .uart_tx(uart_tx), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Storage: data valid one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d chars, expected %0d chars", name, act.len(), exp.len());
        end
    endtask

    task automatic push_str(input string s);
        for (int k = 0; k < s.len(); k++) exp_bytes.push_back(s[k]);
    endtask

    function automatic string hdr_prefix(input int m, input int n);
        string s;
        s = "";
`ifdef MATRIX_PRINT_HEADER_EN
        s = $sformatf("%0d %0d%c%c", m, n, 8'd13, 8'd10);
`endif
        return s;
    endfunction

    // Reference model: what the printer must emit for the current memory contents.
    task automatic model_job(input logic [7:0] b, input int m, input int n);
        logic [7:0]  a;
        logic [31:0] v;
        push_str(hdr_prefix(m, n));
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                a = 8'(b + r * n + c);
                exp_addr.push_back(a);
                v = mem[a];
                if (v[31:16] != 16'd0) push_str("*");
                else                   push_str($sformatf("%0d", v[15:0]));
                if (c == n - 1) push_str(crlf);
                else            push_str(" ");
            end
        end
    endtask

    function automatic logic [31:0] rand_val();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       return 32'd0;
            1:       return {16'($urandom_range(1, 65535)), 16'($urandom)};
            2:       return 32'd65535;
            3, 4:    return 32'($urandom_range(0, 99));
            default: return 32'($urandom_range(0, 65535));
        endcase
    endfunction

    // UART monitor: checks every bit lasts CPB cycles, then scores the byte.
    initial begin : uart_mon
        logic [9:0] bits;
        logic [7:0] got;
        logic       v;
        bit         ok, ab;
        forever begin
            @(negedge clk);
            if (rst_n && !uart_tx) begin
                ok = 1'b1;
                ab = 1'b0;
                bits = 10'd0;
                for (int b = 0; b < 10; b++) begin
                    v = 1'b0;
                    for (int k = 0; k < CPB; k++) begin
                        if (!(b == 0 && k == 0)) @(negedge clk);
                        if (!rst_n) begin
                            ab = 1'b1;
                            break;
                        end
                        if (k == 0) v = uart_tx;
                        else if (uart_tx !== v) ok = 1'b0;
                    end
                    if (ab) break;
                    bits[b] = v;
                end
                if (!ab) begin
                    chk("uart_frame", {29'd0, ok, bits[0], bits[9]}, 32'd5);
                    got = bits[8:1];
                    rx_str = $sformatf("%s%c", rx_str, got);
                    rx_count++;
                    if (exp_bytes.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL uart_unexpected_byte: got %0h, expected none", got);
                    end else begin
                        chk("uart_byte", got, exp_bytes.pop_front());
                    end
                end
            end
        end
    end

    // Read-strobe monitor.
    initial begin : rd_mon
        forever begin
            @(negedge clk);
            if (rst_n && rd_en) begin
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got addr %0h, expected no read", rd_addr);
                end else begin
                    chk("rd_addr", rd_addr, exp_addr.pop_front());
                end
            end
        end
    end

    // Done monitor: busy must already be low in the done cycle.
    initial begin : done_mon
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                chk("busy_low_at_done", busy, 0);
            end
        end
    end

    task automatic pulse_start(input logic [7:0] b, input int m, input int n);
        @(posedge clk);
        #1;
        base_addr = b;
        dim_m = 3'(m);
        dim_n = 3'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        base_addr = 8'($urandom);
        dim_m = 3'($urandom);
        dim_n = 3'($urandom);
    endtask

    task automatic run_job(input logic [7:0] b, input int m, input int n, input bit rebump);
        int d0;
        bit seen;
        d0 = done_cnt;
        rx_str = "";
        model_job(b, m, n);
        pulse_start(b, m, n);
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        if (rebump) begin
            repeat (40) @(posedge clk);
            #1;
            base_addr = ~b;
            dim_m = 3'd1;
            dim_n = 3'd1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_seen", {31'd0, seen}, 1);
        repeat (4) @(negedge clk);
        chk("done_count", done_cnt - d0, 1);
        chk("bytes_left", exp_bytes.size(), 0);
        chk("addrs_left", exp_addr.size(), 0);
        exp_bytes.delete();
        exp_addr.delete();
    endtask

    task automatic bad_start(input int m, input int n);
        int bad;
        pulse_start(8'($urandom), m, n);
        @(negedge clk);
        chk("error_pulse", error, 1);
        chk("busy_on_reject", busy, 0);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (error || busy || rd_en || !uart_tx) bad++;
        end
        chk("reject_quiet", bad, 0);
    endtask

    initial begin : main
        bit found;
        int r0;
        crlf = $sformatf("%c%c", 8'd13, 8'd10);
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        repeat (3) @(negedge clk);
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 6; i++) mem[8'h10 + i] = 32'(i + 1);
        run_job(8'h10, 2, 3, 1'b0);
        chk_s("stream_2x3", rx_str, {hdr_prefix(2, 3), "1 2 3", crlf, "4 5 6", crlf});

        mem[8'h80] = 32'd65535;
        run_job(8'h80, 1, 1, 1'b0);
        chk_s("stream_65535", rx_str, {hdr_prefix(1, 1), "65535", crlf});
        mem[8'h80] = 32'd0;
        run_job(8'h80, 1, 1, 1'b0);
        chk_s("stream_zero", rx_str, {hdr_prefix(1, 1), "0", crlf});
        mem[8'h80] = 32'h0001_0000;
        run_job(8'h80, 1, 1, 1'b0);
        chk_s("stream_star", rx_str, {hdr_prefix(1, 1), "*", crlf});

        mem[8'h20] = 32'd7; mem[8'h21] = 32'd8; mem[8'h22] = 32'd9; mem[8'h23] = 32'd0;
        run_job(8'h20, 2, 2, 1'b0);
        chk_s("stream_2x2", rx_str, {hdr_prefix(2, 2), "7 8", crlf, "9 0", crlf});

        for (int i = 0; i < 6; i++) mem[8'(8'hFC + i)] = rand_val();
        run_job(8'hFC, 2, 3, 1'b1);

        bad_start(0, 3);
        bad_start(2, 6);
        bad_start(6, 1);
        bad_start(3, 0);

        for (int i = 0; i < 9; i++) mem[8'h40 + i] = 32'($urandom_range(10000, 65535));
        model_job(8'h40, 3, 3);
        r0 = rx_count;
        pulse_start(8'h40, 3, 3);
        found = 1'b0;
        for (int i = 0; i < BUDGET && !found; i++) begin
            @(negedge clk);
            if (rx_count >= r0 + 2 && !uart_tx) found = 1'b1;
        end
        chk("reached_mid_byte", {31'd0, found}, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_uart_tx", uart_tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_en", rd_en, 0);
        repeat (CPB * 12) @(negedge clk);
        chk("midrst_line_held", uart_tx, 1);
        exp_bytes.delete();
        exp_addr.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_idle", {30'd0, busy, uart_tx}, 1);
        run_job(8'h40, 3, 3, 1'b1);

        for (int j = 0; j < 6; j++) begin
            logic [7:0] b;
            int m, n;
            b = 8'($urandom);
            m = $urandom_range(1, 5);
            n = $urandom_range(1, 5);
            for (int i = 0; i < m * n; i++) mem[8'(b + i)] = rand_val();
            run_job(b, m, n, (j % 2) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
